// File: rtl/control_unit.sv
// Multicycle main-control FSM: sequences fetch, decode, execute, memory and
// write-back micro-steps for add/sub/and, addi, lw, sw, beq, bne and j.
module control_unit #(
    parameter int MEM_WAIT_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       alu_zero,
    input  logic       alu_ovf,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       iord,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mdr_write,
    output logic       ab_write,
    output logic       aluout_write,
    output logic       epc_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_func,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_RESET      = 4'd0,
        S_FETCH      = 4'd1,
        S_FETCH_WAIT = 4'd2,
        S_DECODE     = 4'd3,
        S_EXEC_R     = 4'd4,
        S_WB_R       = 4'd5,
        S_EXEC_I     = 4'd6,
        S_WB_I       = 4'd7,
        S_ADDR       = 4'd8,
        S_MEM_RD     = 4'd9,
        S_MEM_WAIT   = 4'd10,
        S_WB_LW      = 4'd11,
        S_MEM_WR     = 4'd12,
        S_BRANCH     = 4'd13,
        S_JUMP       = 4'd14,
        S_EXCEPT     = 4'd15
    } state_t;

    localparam int CW = (MEM_WAIT_CYCLES > 1) ? $clog2(MEM_WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(MEM_WAIT_CYCLES - 1);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;

    state_t        state_q, state_d;
    logic [CW-1:0] wait_q, wait_d;
    logic          wait_last;
    logic          funct_ok;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_RESET;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    assign wait_last = (wait_q == WAIT_LAST);
    assign funct_ok  = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND);
    assign state     = state_q;

    always_comb begin
        state_d      = state_q;
        wait_d       = '0;
        pc_write     = 1'b0;
        pc_src       = 2'b00;
        iord         = 1'b0;
        mem_write    = 1'b0;
        ir_write     = 1'b0;
        mdr_write    = 1'b0;
        ab_write     = 1'b0;
        aluout_write = 1'b0;
        epc_write    = 1'b0;
        reg_write    = 1'b0;
        reg_dst      = 1'b0;
        mem_to_reg   = 1'b0;
        alu_src_a    = 1'b0;
        alu_src_b    = 2'b00;
        alu_func     = 3'b000;

        unique case (state_q)
            S_RESET: state_d = S_FETCH;
            S_FETCH: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b01;
                alu_func  = 3'b001;
                pc_write  = 1'b1;
                state_d   = S_FETCH_WAIT;
            end
            // Memory latency is absorbed here; the IR loads only once data is valid.
            S_FETCH_WAIT: begin
                if (wait_last) begin
                    ir_write = 1'b1;
                    state_d  = S_DECODE;
                end else begin
                    wait_d = wait_q + CW'(1);
                end
            end
            S_DECODE: begin
                ab_write     = 1'b1;
                alu_src_a    = 1'b1;
                alu_src_b    = 2'b11;
                alu_func     = 3'b001;
                aluout_write = 1'b1;
                if (opcode == OP_RTYPE && funct_ok)            state_d = S_EXEC_R;
                else if (opcode == OP_ADDI)                    state_d = S_EXEC_I;
                else if (opcode == OP_LW || opcode == OP_SW)   state_d = S_ADDR;
                else if (opcode == OP_BEQ || opcode == OP_BNE) state_d = S_BRANCH;
                else if (opcode == OP_J)                       state_d = S_JUMP;
                else                                           state_d = S_EXCEPT;
            end
            S_EXEC_R: begin
                aluout_write = 1'b1;
                if (funct == FN_SUB)      alu_func = 3'b010;
                else if (funct == FN_AND) alu_func = 3'b011;
                else                      alu_func = 3'b001;
                // Logical AND cannot overflow, so only add/sub trap.
                state_d = (alu_ovf && funct != FN_AND) ? S_EXCEPT : S_WB_R;
            end
            S_WB_R: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                state_d   = S_FETCH;
            end
            S_EXEC_I: begin
                alu_src_b    = 2'b10;
                alu_func     = 3'b001;
                aluout_write = 1'b1;
                state_d      = alu_ovf ? S_EXCEPT : S_WB_I;
            end
            S_WB_I: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_ADDR: begin
                alu_src_b    = 2'b10;
                alu_func     = 3'b001;
                aluout_write = 1'b1;
                state_d      = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                iord    = 1'b1;
                state_d = S_MEM_WAIT;
            end
            S_MEM_WAIT: begin
                iord = 1'b1;
                if (wait_last) begin
                    mdr_write = 1'b1;
                    state_d   = S_WB_LW;
                end else begin
                    wait_d = wait_q + CW'(1);
                end
            end
            S_WB_LW: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_WR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_func = 3'b010;
                pc_src   = 2'b01;
                pc_write = ((opcode == OP_BEQ) && alu_zero) || ((opcode == OP_BNE) && !alu_zero);
                state_d  = S_FETCH;
            end
            S_JUMP: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
                state_d  = S_FETCH;
            end
            // PC already points past the faulting instruction, so EPC = PC - 4.
            S_EXCEPT: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b01;
                alu_func  = 3'b010;
                epc_write = 1'b1;
                pc_src    = 2'b11;
                pc_write  = 1'b1;
                state_d   = S_FETCH;
            end
            default: state_d = S_RESET;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: two instances (1 and 3 memory wait
// cycles) checked against an instruction-level model of state traces and strobe counts.
module tb_control_unit;

    typedef logic [3:0] trace_t[$];

    logic       clk = 1'b0;
    logic       reset[2];
    logic [5:0] opcode[2], funct[2];
    logic       alu_zero[2], alu_ovf[2];
    logic       pc_write[2], iord[2], mem_write[2], ir_write[2], mdr_write[2];
    logic       ab_write[2], aluout_write[2], epc_write[2], reg_write[2];
    logic       reg_dst[2], mem_to_reg[2], alu_src_a[2];
    logic [1:0] pc_src[2], alu_src_b[2];
    logic [2:0] alu_func[2];
    logic [3:0] state[2];

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    control_unit #(.MEM_WAIT_CYCLES(1)) dut_w1 (
        .clk(clk), .reset(reset[0]), .opcode(opcode[0]), .funct(funct[0]),
        .alu_zero(alu_zero[0]), .alu_ovf(alu_ovf[0]), .pc_write(pc_write[0]),
        .pc_src(pc_src[0]), .iord(iord[0]), .mem_write(mem_write[0]),
        .ir_write(ir_write[0]), .mdr_write(mdr_write[0]), .ab_write(ab_write[0]),
        .aluout_write(aluout_write[0]), .epc_write(epc_write[0]),
        .reg_write(reg_write[0]), .reg_dst(reg_dst[0]), .mem_to_reg(mem_to_reg[0]),
        .alu_src_a(alu_src_a[0]), .alu_src_b(alu_src_b[0]), .alu_func(alu_func[0]),
        .state(state[0])
    );

    control_unit #(.MEM_WAIT_CYCLES(3)) dut_w3 (
        .clk(clk), .reset(reset[1]), .opcode(opcode[1]), .funct(funct[1]),
        .alu_zero(alu_zero[1]), .alu_ovf(alu_ovf[1]), .pc_write(pc_write[1]),
        .pc_src(pc_src[1]), .iord(iord[1]), .mem_write(mem_write[1]),
        .ir_write(ir_write[1]), .mdr_write(mdr_write[1]), .ab_write(ab_write[1]),
        .aluout_write(aluout_write[1]), .epc_write(epc_write[1]),
        .reg_write(reg_write[1]), .reg_dst(reg_dst[1]), .mem_to_reg(mem_to_reg[1]),
        .alu_src_a(alu_src_a[1]), .alu_src_b(alu_src_b[1]), .alu_func(alu_func[1]),
        .state(state[1])
    );

    function automatic int waits_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic logic [18:0] all_outs(input int d);
        return {pc_write[d], pc_src[d], iord[d], mem_write[d], ir_write[d], mdr_write[d],
                ab_write[d], aluout_write[d], epc_write[d], reg_write[d], reg_dst[d],
                mem_to_reg[d], alu_src_a[d], alu_src_b[d], alu_func[d]};
    endfunction

    function automatic bit is_rtype(input logic [5:0] op, input logic [5:0] fn);
        return op == 6'h00 && (fn == 6'h20 || fn == 6'h22 || fn == 6'h24);
    endfunction

    function automatic bit is_known(input logic [5:0] op, input logic [5:0] fn);
        return is_rtype(op, fn) || op == 6'h08 || op == 6'h23 || op == 6'h2B ||
               op == 6'h04 || op == 6'h05 || op == 6'h02;
    endfunction

    function automatic bit traps(input logic [5:0] op, input logic [5:0] fn, input logic ovf);
        return !is_known(op, fn) || (is_rtype(op, fn) && ovf && fn != 6'h24) ||
               (op == 6'h08 && ovf);
    endfunction

    // Expected visited state codes for one instruction, starting at fetch.
    function automatic trace_t build_trace(input int n, input logic [5:0] op,
                                           input logic [5:0] fn, input logic ovf);
        trace_t t;
        t.push_back(4'd1);
        for (int i = 0; i < n; i++) t.push_back(4'd2);
        t.push_back(4'd3);
        if (is_rtype(op, fn))                t.push_back(4'd4);
        else if (op == 6'h08)                t.push_back(4'd6);
        else if (op == 6'h23 || op == 6'h2B) t.push_back(4'd8);
        if (traps(op, fn, ovf)) begin
            t.push_back(4'd15);
        end else if (is_rtype(op, fn)) begin
            t.push_back(4'd5);
        end else if (op == 6'h08) begin
            t.push_back(4'd7);
        end else if (op == 6'h23) begin
            t.push_back(4'd9);
            for (int i = 0; i < n; i++) t.push_back(4'd10);
            t.push_back(4'd11);
        end else if (op == 6'h2B) begin
            t.push_back(4'd12);
        end else if (op == 6'h02) begin
            t.push_back(4'd14);
        end else begin
            t.push_back(4'd13);
        end
        return t;
    endfunction

    task automatic sync_to_fetch(input int d);
        reset[d] = 1'b0;
        @(posedge clk); @(negedge clk);
        reset[d] = 1'b1;
        @(posedge clk); @(negedge clk); #1;
    endtask

    // Runs one instruction from FETCH on dut d, checking trace, strobe counts and key selects.
    task automatic run_instr(input int d, input logic [5:0] op, input logic [5:0] fn,
                             input logic z, input logic ovf, input string tag);
        trace_t tr;
        int n_ir = 0, n_mdr = 0, n_mem = 0, n_reg = 0, n_epc = 0, n_pc = 0, n_both = 0;
        logic [1:0] late_src = 2'b00;
        bit exc, wb_ok, taken;
        int exp_pc;
        logic [1:0] exp_src;
        opcode[d] = op; funct[d] = fn; alu_zero[d] = z; alu_ovf[d] = ovf;
        #1;
        tr = build_trace(waits_of(d), op, fn, ovf);
        exc   = traps(op, fn, ovf);
        wb_ok = !exc && (is_rtype(op, fn) || op == 6'h08 || op == 6'h23);
        taken = (op == 6'h04 && z) || (op == 6'h05 && !z);
        exp_pc  = 1 + ((op == 6'h02 || exc || taken) ? 1 : 0);
        exp_src = exc ? 2'b11 : (op == 6'h02) ? 2'b10 : 2'b01;
        for (int k = 0; k < tr.size(); k++) begin
            tests_run++;
            if (state[d] !== tr[k]) begin
                tests_failed++;
                $display("[TB] FAIL %s step %0d state: got %0d want %0d", tag, k, state[d], tr[k]);
            end
            if (k == 0) begin
                tests_run++;
                if ({pc_write[d], pc_src[d], iord[d], alu_src_a[d], alu_src_b[d], alu_func[d]} !== 10'b1_00_0_1_01_001) begin
                    tests_failed++;
                    $display("[TB] FAIL %s fetch selects: got %b", tag,
                             {pc_write[d], pc_src[d], iord[d], alu_src_a[d], alu_src_b[d], alu_func[d]});
                end
            end
            if (reg_write[d] === 1'b1) begin
                tests_run++;
                if ({reg_dst[d], mem_to_reg[d]} !== {is_rtype(op, fn), op == 6'h23}) begin
                    tests_failed++;
                    $display("[TB] FAIL %s wb selects: got dst=%b m2r=%b", tag, reg_dst[d], mem_to_reg[d]);
                end
            end
            if (epc_write[d] === 1'b1) begin
                tests_run++;
                if ({alu_src_a[d], alu_src_b[d], alu_func[d], pc_src[d], pc_write[d]} !== 9'b1_01_010_11_1) begin
                    tests_failed++;
                    $display("[TB] FAIL %s except selects: got %b", tag,
                             {alu_src_a[d], alu_src_b[d], alu_func[d], pc_src[d], pc_write[d]});
                end
            end
            n_ir  += int'(ir_write[d]);
            n_mdr += int'(mdr_write[d]);
            n_mem += int'(mem_write[d]);
            n_reg += int'(reg_write[d]);
            n_epc += int'(epc_write[d]);
            n_pc  += int'(pc_write[d]);
            n_both += int'(mem_write[d] & reg_write[d]);
            if (k > 0 && pc_write[d] === 1'b1) late_src = pc_src[d];
            @(posedge clk); @(negedge clk); #1;
        end
        tests_run++;
        if (state[d] !== 4'd1) begin
            tests_failed++;
            $display("[TB] FAIL %s return to fetch: got %0d want 1", tag, state[d]);
        end
        tests_run++;
        if ({n_ir, n_mdr, n_mem, n_reg, n_epc, n_pc, n_both} !==
            {32'd1, (op == 6'h23 && !exc) ? 32'd1 : 32'd0, (op == 6'h2B) ? 32'd1 : 32'd0,
             wb_ok ? 32'd1 : 32'd0, exc ? 32'd1 : 32'd0, exp_pc, 32'd0}) begin
            tests_failed++;
            $display("[TB] FAIL %s strobe counts: got ir=%0d mdr=%0d mem=%0d reg=%0d epc=%0d pc=%0d both=%0d",
                     tag, n_ir, n_mdr, n_mem, n_reg, n_epc, n_pc, n_both);
        end
        if (exp_pc == 2) begin
            tests_run++;
            if (late_src !== exp_src) begin
                tests_failed++;
                $display("[TB] FAIL %s pc_src: got %b want %b", tag, late_src, exp_src);
            end
        end
    endtask

    task automatic test_reset();
        for (int d = 0; d < 2; d++) begin
            reset[d] = 1'b0; opcode[d] = 6'h00; funct[d] = 6'h20;
            alu_zero[d] = 1'b0; alu_ovf[d] = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset[0] = 1'b1; reset[1] = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            tests_run++;
            if (state[d] !== 4'd0 || all_outs(d) !== 19'd0) begin
                tests_failed++;
                $display("[TB] FAIL reset dut%0d: got state=%0d outs=%b", d, state[d], all_outs(d));
            end
        end
        @(posedge clk); @(negedge clk); #1;
        for (int d = 0; d < 2; d++) begin
            tests_run++;
            if (state[d] !== 4'd1 || pc_write[d] !== 1'b1 || alu_func[d] !== 3'b001) begin
                tests_failed++;
                $display("[TB] FAIL first fetch dut%0d: got state=%0d pc_write=%b alu_func=%b",
                         d, state[d], pc_write[d], alu_func[d]);
            end
        end
    endtask

    task automatic test_r_type();
        sync_to_fetch(0);
        run_instr(0, 6'h00, 6'h20, 1'b0, 1'b0, "add");
        run_instr(0, 6'h00, 6'h22, 1'b1, 1'b0, "sub");
        run_instr(0, 6'h00, 6'h24, 1'b0, 1'b1, "and_ovf_ignored");
    endtask

    task automatic test_mem_wait();
        sync_to_fetch(1);
        run_instr(1, 6'h23, 6'h00, 1'b0, 1'b0, "lw_w3");
        run_instr(1, 6'h2B, 6'h11, 1'b0, 1'b0, "sw_w3");
        sync_to_fetch(0);
        run_instr(0, 6'h23, 6'h00, 1'b0, 1'b0, "lw_w1");
    endtask

    task automatic test_branch();
        sync_to_fetch(0);
        run_instr(0, 6'h04, 6'h00, 1'b1, 1'b0, "beq_taken");
        run_instr(0, 6'h05, 6'h00, 1'b1, 1'b0, "bne_not_taken");
        run_instr(0, 6'h05, 6'h00, 1'b0, 1'b0, "bne_taken");
        run_instr(0, 6'h02, 6'h00, 1'b0, 1'b0, "jump");
    endtask

    task automatic test_exceptions();
        sync_to_fetch(0);
        run_instr(0, 6'h3F, 6'h00, 1'b0, 1'b0, "undef_op");
        run_instr(0, 6'h08, 6'h00, 1'b0, 1'b1, "addi_ovf");
        run_instr(0, 6'h00, 6'h22, 1'b0, 1'b1, "sub_ovf");
        run_instr(0, 6'h00, 6'h07, 1'b0, 1'b0, "undef_funct");
    endtask

    task automatic test_reset_in_mem_wr();
        sync_to_fetch(0);
        opcode[0] = 6'h2B; funct[0] = 6'h00;
        repeat (4) begin
            @(posedge clk);
        end
        @(negedge clk); #1;
        tests_run++;
        if (state[0] !== 4'd12 || mem_write[0] !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL reach mem_wr: got state=%0d mem_write=%b", state[0], mem_write[0]);
        end
        reset[0] = 1'b0;
        @(posedge clk); @(negedge clk); #1;
        tests_run++;
        if (state[0] !== 4'd0 || mem_write[0] !== 1'b0 || reg_write[0] !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL mid-reset: got state=%0d mem_write=%b reg_write=%b",
                     state[0], mem_write[0], reg_write[0]);
        end
        reset[0] = 1'b1;
        @(posedge clk); @(negedge clk); #1;
        tests_run++;
        if (state[0] !== 4'd1) begin
            tests_failed++;
            $display("[TB] FAIL restart after reset: got %0d want 1", state[0]);
        end
    endtask

    task automatic test_random();
        logic [5:0] op, fn;
        logic [5:0] ops[7];
        ops = '{6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02};
        for (int d = 0; d < 2; d++) begin
            sync_to_fetch(d);
            for (int i = 0; i < 30; i++) begin
                int pick;
                pick = int'($urandom_range(0, 7));
                op = (pick == 7) ? 6'($urandom_range(0, 63)) : ops[pick];
                case ($urandom_range(0, 3))
                    0:       fn = 6'h20;
                    1:       fn = 6'h22;
                    2:       fn = 6'h24;
                    default: fn = 6'($urandom_range(0, 63));
                endcase
                run_instr(d, op, fn, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          $sformatf("rand_d%0d_%0d", d, i));
            end
        end
    endtask

    initial begin
        test_reset();
        test_r_type();
        test_mem_wait();
        test_branch();
        test_exceptions();
        test_reset_in_mem_wr();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
